// File: rtl/pipeline_stall_controller.sv
// Hazard stall/flush control for a 5-stage pipeline: load-use and HI/LO-vs-MDU interlocks.
// Stall is combinational (same cycle); MDU occupancy and stall statistics are registered.
module pipeline_stall_controller #(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_RegisterRt,
  input  logic [4:0]  IFID_RegisterRs,
  input  logic [4:0]  IFID_RegisterRt,
  input  logic        IFID_UsesHILO,
  input  logic        IFID_IsMDU,
  input  logic        MDU_Start,
  input  logic        Branch_Taken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        OP,
  output logic        IFIDFlush,
  output logic        MDU_Busy,
  output logic [15:0] StallCycles
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [5:0] CNT_INIT = 6'(MDU_LATENCY - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mdu_haz;
  logic stall;

  // Register 0 is hardwired zero, so a load "into" it can never create a dependency.
  assign load_use = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
                    ((IDEX_RegisterRt == IFID_RegisterRs) ||
                     (IDEX_RegisterRt == IFID_RegisterRt));
  assign mdu_haz  = (state_q == BUSY) && (IFID_UsesHILO || IFID_IsMDU);
  assign stall    = load_use || mdu_haz;

  // Reset forces every pipeline enable low so nothing advances while held.
  assign PCWrite     = ~rst & ~stall;
  assign IFIDWrite   = ~rst & ~stall;
  assign OP          = ~rst & ~stall;
  assign IFIDFlush   = ~rst & Branch_Taken & ~stall;
  assign MDU_Busy    = (state_q == BUSY);
  assign StallCycles = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      RUN: begin
        if (MDU_Start) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        // A new MDU_Start here is dropped; the unit cannot accept back-to-back ops.
        if (cnt_q == 6'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 6'd0;
      end
    endcase

    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 6'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: per-cycle comparison against an occupancy/count model plus pinned scenarios.
module tb_pipeline_stall_controller;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IDEX_MemRead = 1'b0;
  logic [4:0]  IDEX_RegisterRt = 5'd0;
  logic [4:0]  IFID_RegisterRs = 5'd0;
  logic [4:0]  IFID_RegisterRt = 5'd0;
  logic        IFID_UsesHILO = 1'b0;
  logic        IFID_IsMDU = 1'b0;
  logic        MDU_Start = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic        PCWrite, IFIDWrite, OP, IFIDFlush, MDU_Busy;
  logic [15:0] StallCycles;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: remaining MDU occupancy cycles and a saturating stall tally.
  int m_rem = 0;
  int m_cnt = 0;

  pipeline_stall_controller #(.MDU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRt(IDEX_RegisterRt),
    .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
    .IFID_UsesHILO(IFID_UsesHILO), .IFID_IsMDU(IFID_IsMDU),
    .MDU_Start(MDU_Start), .Branch_Taken(Branch_Taken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .OP(OP), .IFIDFlush(IFIDFlush),
    .MDU_Busy(MDU_Busy), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    bit lu, mh;
    lu = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
         (IDEX_RegisterRt == IFID_RegisterRs || IDEX_RegisterRt == IFID_RegisterRt);
    mh = (m_rem > 0) && (IFID_UsesHILO || IFID_IsMDU);
    return lu || mh;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem <= 0;
      m_cnt <= 0;
    end else begin
      if (model_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (m_rem > 0) m_rem <= m_rem - 1;
      else if (MDU_Start) m_rem <= LAT;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit s;
      s = model_stall();
      chk1("cyc_pcwrite",  PCWrite,   !rst && !s);
      chk1("cyc_ifidwrite", IFIDWrite, !rst && !s);
      chk1("cyc_op",       OP,        !rst && !s);
      chk1("cyc_flush",    IFIDFlush, !rst && !s && Branch_Taken);
      chk1("cyc_busy",     MDU_Busy,  m_rem > 0);
      chk16("cyc_stallcnt", StallCycles, 16'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    IDEX_MemRead = 1'b0; IDEX_RegisterRt = 5'd0;
    IFID_RegisterRs = 5'd0; IFID_RegisterRt = 5'd0;
    IFID_UsesHILO = 1'b0; IFID_IsMDU = 1'b0;
    MDU_Start = 1'b0; Branch_Taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    chk_en = 1'b1;
    tick();
    IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd3; IFID_RegisterRs = 5'd3; Branch_Taken = 1'b1;
    mid();
    chk1("rst_pcwrite", PCWrite, 1'b0);
    chk1("rst_flush", IFIDFlush, 1'b0);
    chk1("rst_busy", MDU_Busy, 1'b0);
    chk16("rst_cnt", StallCycles, 16'd0);
    tick();
    rst = 1'b0;
    clear_inputs();

    // Load-use on Rs, then r0 never stalls
    IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd5; IFID_RegisterRs = 5'd5;
    mid();
    chk1("lu_pcwrite", PCWrite, 1'b0);
    chk1("lu_op", OP, 1'b0);
    chk16("lu_cnt_before", StallCycles, 16'd0);
    tick();
    IDEX_RegisterRt = 5'd0; IFID_RegisterRs = 5'd0;
    mid();
    chk16("lu_cnt_after", StallCycles, 16'd1);
    chk1("r0_pcwrite", PCWrite, 1'b1);
    tick();

    // Branch without and with hazard
    clear_inputs();
    Branch_Taken = 1'b1;
    mid();
    chk1("br_flush", IFIDFlush, 1'b1);
    tick();
    IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd9; IFID_RegisterRt = 5'd9;
    mid();
    chk1("br_lu_flush", IFIDFlush, 1'b0);
    chk1("br_lu_pcwrite", PCWrite, 1'b0);
    tick();

    // MDU occupancy with HI/LO reader held
    do_reset();
    MDU_Start = 1'b1;
    tick();
    MDU_Start = 1'b0; IFID_UsesHILO = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      mid();
      chk1("mdu_busy", MDU_Busy, k <= LAT);
      chk1("mdu_pcwrite", PCWrite, k > LAT);
      tick();
    end
    mid();
    chk16("mdu_cnt", StallCycles, 16'd4);
    tick();

    // Start held continuously: exit edge ignores it, next RUN edge restarts
    do_reset();
    MDU_Start = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      mid();
      chk1("mdu_hold_busy", MDU_Busy, k != LAT + 1);
      tick();
    end
    MDU_Start = 1'b0;

    // Independent instructions flow through during BUSY
    do_reset();
    MDU_Start = 1'b1;
    tick();
    MDU_Start = 1'b0;
    IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd4; IFID_RegisterRs = 5'd6; IFID_RegisterRt = 5'd7;
    for (int k = 1; k <= LAT; k++) begin
      mid();
      chk1("indep_pcwrite", PCWrite, 1'b1);
      chk16("indep_cnt", StallCycles, 16'd0);
      tick();
    end

    // Reset during BUSY
    do_reset();
    MDU_Start = 1'b1;
    tick();
    MDU_Start = 1'b0; IFID_IsMDU = 1'b1;
    tick();
    mid();
    chk16("rb_cnt_pre", StallCycles, 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk1("rb_busy", MDU_Busy, 1'b0);
    chk16("rb_cnt", StallCycles, 16'd0);
    chk1("rb_pcwrite", PCWrite, 1'b0);
    tick();
    rst = 1'b0;
    mid();
    chk1("rb_after_busy", MDU_Busy, 1'b0);
    chk1("rb_after_pcwrite", PCWrite, 1'b1);
    tick();

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(99) == 0);
      IDEX_MemRead    = ($urandom_range(99) < 35);
      IDEX_RegisterRt = 5'($urandom_range(3));
      IFID_RegisterRs = 5'($urandom_range(3));
      IFID_RegisterRt = 5'($urandom_range(3));
      IFID_UsesHILO   = ($urandom_range(99) < 20);
      IFID_IsMDU      = ($urandom_range(99) < 15);
      MDU_Start       = ($urandom_range(99) < 25);
      Branch_Taken    = ($urandom_range(99) < 25);
      tick();
    end
    rst = 1'b0;

    // Saturation of the stall counter
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd7; IFID_RegisterRs = 5'd7;
    repeat (65540) tick();
    mid();
    chk16("sat_cnt", StallCycles, 16'hFFFF);
    tick();
    clear_inputs();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
